// File: rtl/fpu_wb_queue.sv
// Writeback queue for the FPU: buffers fixed-latency result beats (PRF or FCR bound)
// and hands them to writeback over valid/ready, issuing start credits so no beat is lost.
module fpu_wb_queue #(
    parameter int LG_PRF_WIDTH = 4,
    parameter int LG_ROB_WIDTH = 4,
    parameter int LG_FCR_WIDTH = 4,
    parameter int FPU_LAT      = 2,
    parameter int LG_DEPTH     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_start,
    output logic                    issue_ok,
    input  logic                    fpu_val,
    input  logic                    fpu_cmp_val,
    input  logic [63:0]             fpu_y,
    input  logic [LG_ROB_WIDTH-1:0] fpu_rob_ptr,
    input  logic [LG_PRF_WIDTH-1:0] fpu_dst_ptr,
    input  logic [LG_FCR_WIDTH-1:0] fpu_fcr_ptr,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic                    wb_is_fcr,
    output logic [63:0]             wb_data,
    output logic [LG_ROB_WIDTH-1:0] wb_rob_ptr,
    output logic [LG_PRF_WIDTH-1:0] wb_dst_ptr,
    output logic [LG_FCR_WIDTH-1:0] wb_fcr_ptr,
    output logic [LG_DEPTH:0]       occupancy,
    output logic                    err
);

    localparam int DEPTH = 1 << LG_DEPTH;
    localparam int CW    = LG_DEPTH + 1;
    localparam int EW    = 1 + 64 + LG_ROB_WIDTH + LG_PRF_WIDTH + LG_FCR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_SUM  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [LG_DEPTH-1:0] PTR_ONE = LG_DEPTH'(1);

    logic [EW-1:0]       mem_r [DEPTH];
    logic [LG_DEPTH-1:0] wr_ptr_r;
    logic [LG_DEPTH-1:0] rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       inflight_r;
    logic                err_r;

    logic                push_req_s;
    logic                push_acc_s;
    logic                pop_s;
    logic                full_s;
    logic                inflight_dec_s;
    logic                credit_ok_s;
    logic                err_set_s;
    logic [CW:0]         credit_sum_s;
    logic [CW-1:0]       count_n_s;
    logic [CW-1:0]       inflight_n_s;
    logic [EW-1:0]       wr_entry_s;

    // Handshake decode, credit check, protocol-error detection and next counters.
    always_comb begin
        push_req_s     = fpu_val | fpu_cmp_val;
        full_s         = (count_r == DEPTH_C);
        pop_s          = (count_r != {CW{1'b0}}) & wb_ready;
        push_acc_s     = push_req_s & (~full_s | pop_s);
        inflight_dec_s = push_req_s & (inflight_r != {CW{1'b0}});
        credit_sum_s   = {1'b0, count_r} + {1'b0, inflight_r};
        credit_ok_s    = (credit_sum_s < DEPTH_SUM);
        wr_entry_s     = {fpu_cmp_val, fpu_y, fpu_rob_ptr, fpu_dst_ptr, fpu_fcr_ptr};
        err_set_s      = (push_req_s & full_s & ~pop_s)
                       | (fpu_val & fpu_cmp_val)
                       | (push_req_s & (inflight_r == {CW{1'b0}}))
                       | (issue_start & ~credit_ok_s);

        if (push_acc_s && !pop_s) begin
            count_n_s = count_r + CNT_ONE;
        end else if (!push_acc_s && pop_s) begin
            count_n_s = count_r - CNT_ONE;
        end else begin
            count_n_s = count_r;
        end

        // Saturate at both ends so a misbehaving scheduler cannot wrap the credit count.
        if (issue_start && !inflight_dec_s) begin
            inflight_n_s = (inflight_r == CNT_MAX) ? inflight_r : inflight_r + CNT_ONE;
        end else if (!issue_start && inflight_dec_s) begin
            inflight_n_s = inflight_r - CNT_ONE;
        end else begin
            inflight_n_s = inflight_r;
        end
    end

    // Control state: pointers, counters and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {LG_DEPTH{1'b0}};
            rd_ptr_r   <= {LG_DEPTH{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= {CW{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_n_s;
            inflight_r <= inflight_n_s;
            err_r      <= err_r | err_set_s;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_acc_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Outputs come straight from flops; only issue_ok is also gated by reset.
    assign {wb_is_fcr, wb_data, wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr} = mem_r[rd_ptr_r];
    assign wb_valid  = (count_r != {CW{1'b0}});
    assign occupancy = count_r;
    assign err       = err_r;
    assign issue_ok  = reset & credit_ok_s;

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Scoreboard bench for fpu_wb_queue: a two-stage FPU model produces beats, stimulus
// queues expected entries, and a negedge monitor compares every accepted head entry.
module tb_fpu_wb_queue;

    typedef struct packed {
        logic        cmp;
        logic [63:0] y;
        logic [3:0]  rob;
        logic [3:0]  dst;
        logic [3:0]  fcr;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_start = 1'b0;
    logic        issue_ok;
    logic        fpu_val, fpu_cmp_val;
    logic [63:0] fpu_y;
    logic [3:0]  fpu_rob_ptr, fpu_dst_ptr, fpu_fcr_ptr;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic        wb_is_fcr;
    logic [63:0] wb_data;
    logic [3:0]  wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr;
    logic [2:0]  occupancy;
    logic        err;

    op_t         cur_op = '0;
    op_t         pipe0, pipe1;
    logic        pv0, pv1;
    logic        f_val = 1'b0;
    logic        f_cmp = 1'b0;
    op_t         f_op = '0;

    logic [76:0] sb[$];
    int          total = 0;
    int          bad = 0;
    int          pops = 0;

    always #5 clk = ~clk;

    fpu_wb_queue #(
        .LG_PRF_WIDTH(4), .LG_ROB_WIDTH(4), .LG_FCR_WIDTH(4), .FPU_LAT(2), .LG_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .issue_start(issue_start), .issue_ok(issue_ok),
        .fpu_val(fpu_val), .fpu_cmp_val(fpu_cmp_val), .fpu_y(fpu_y),
        .fpu_rob_ptr(fpu_rob_ptr), .fpu_dst_ptr(fpu_dst_ptr), .fpu_fcr_ptr(fpu_fcr_ptr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_fcr(wb_is_fcr), .wb_data(wb_data),
        .wb_rob_ptr(wb_rob_ptr), .wb_dst_ptr(wb_dst_ptr), .wb_fcr_ptr(wb_fcr_ptr),
        .occupancy(occupancy), .err(err)
    );

    // Two-cycle FPU valid/payload pipeline, reset together with the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv0 <= 1'b0; pv1 <= 1'b0; pipe0 <= '0; pipe1 <= '0;
        end else begin
            pv0 <= issue_start; pipe0 <= cur_op;
            pv1 <= pv0;         pipe1 <= pipe0;
        end
    end

    assign fpu_val     = (pv1 & ~pipe1.cmp) | f_val;
    assign fpu_cmp_val = (pv1 &  pipe1.cmp) | f_cmp;
    assign fpu_y       = pv1 ? pipe1.y   : f_op.y;
    assign fpu_rob_ptr = pv1 ? pipe1.rob : f_op.rob;
    assign fpu_dst_ptr = pv1 ? pipe1.dst : f_op.dst;
    assign fpu_fcr_ptr = pv1 ? pipe1.fcr : f_op.fcr;

    // Monitor: a valid&ready head seen at negedge transfers at the next posedge.
    always @(negedge clk) begin
        if (reset && wb_valid && wb_ready) begin
            total++;
            pops++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wb_pop: got %h, expected no entry", {wb_is_fcr, wb_data, wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr});
            end else begin
                if ({wb_is_fcr, wb_data, wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr} !== sb[0]) begin
                    bad++;
                    $display("FAIL wb_entry: got %h, expected %h",
                             {wb_is_fcr, wb_data, wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr}, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input op_t op, input bit expect_push);
        cur_op = op;
        issue_start = 1'b1;
        if (expect_push) sb.push_back({op.cmp, op.y, op.rob, op.dst, op.fcr});
        tick();
        issue_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wb_ready = 1'b0;
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int   starts;
        int   stalls;
        int   max_occ;
        op_t  op;

        // Reset and idle.
        #2;
        check("rst_issue_ok_low", 64'(issue_ok), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("idle_issue_ok", 64'(issue_ok), 64'd1);
        check("idle_wb_valid", 64'(wb_valid), 64'd0);
        check("idle_occ", 64'(occupancy), 64'd0);
        check("idle_err", 64'(err), 64'd0);

        // Single DP add: start t, beat t+2, head valid t+3, drained t+4.
        wb_ready = 1'b1;
        issue('{cmp: 1'b0, y: 64'h4008000000000000, rob: 4'd5, dst: 4'd9, fcr: 4'd0}, 1'b1);
        tick();
        check("add_no_bypass", 64'(wb_valid), 64'd0);
        tick();
        check("add_valid_t3", 64'(wb_valid), 64'd1);
        check("add_is_fcr", 64'(wb_is_fcr), 64'd0);
        check("add_data", wb_data, 64'h4008000000000000);
        tick();
        check("add_occ_t4", 64'(occupancy), 64'd0);

        // Compare beat.
        wb_ready = 1'b0;
        issue('{cmp: 1'b1, y: 64'h5, rob: 4'd2, dst: 4'd0, fcr: 4'd3}, 1'b1);
        tick(); tick();
        check("cmp_is_fcr", 64'(wb_is_fcr), 64'd1);
        check("cmp_data", wb_data, 64'h5);
        check("cmp_fcr_ptr", 64'(wb_fcr_ptr), 64'd3);
        wb_ready = 1'b1;
        tick();
        check("cmp_err", 64'(err), 64'd0);

        // Credit stall: scheduler starts whenever allowed, writeback blocked.
        wb_ready = 1'b0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            if (issue_ok) begin
                issue('{cmp: 1'b0, y: 64'h1000 + 64'(i), rob: 4'(i), dst: 4'(i + 8), fcr: 4'd0}, 1'b1);
                starts++;
            end else begin
                tick();
            end
        end
        check("stall_starts", 64'(starts), 64'd4);
        check("stall_issue_ok", 64'(issue_ok), 64'd0);
        check("stall_occ", 64'(occupancy), 64'd4);
        check("stall_err", 64'(err), 64'd0);
        wb_ready = 1'b1;
        check("stall_pop_no_credit", 64'(issue_ok), 64'd0);
        tick();
        check("stall_credit_back", 64'(issue_ok), 64'd1);
        tick(); tick(); tick();
        check("stall_drained", 64'(occupancy), 64'd0);

        // Streaming: 20 back-to-back starts with writeback always ready.
        stalls = 0;
        max_occ = 0;
        for (int i = 0; i < 20; i++) begin
            if (!issue_ok) stalls++;
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            issue('{cmp: 1'b0, y: 64'h3FF0000000000000 + 64'(i), rob: 4'(i), dst: 4'(15 - i), fcr: 4'd0}, 1'b1);
        end
        for (int i = 0; i < 4; i++) tick();
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_max_occ", 64'(max_occ), 64'd1);
        check("stream_drained", 64'(occupancy), 64'd0);
        check("stream_err", 64'(err), 64'd0);

        // Simultaneous arithmetic and compare beat: one FCR entry, err set.
        wb_ready = 1'b0;
        op = '{cmp: 1'b0, y: 64'h77, rob: 4'd7, dst: 4'd1, fcr: 4'd6};
        issue(op, 1'b0);
        sb.push_back({1'b1, op.y, op.rob, op.dst, op.fcr});
        tick();
        f_cmp = 1'b1;
        tick();
        f_cmp = 1'b0;
        check("dual_occ", 64'(occupancy), 64'd1);
        check("dual_is_fcr", 64'(wb_is_fcr), 64'd1);
        check("dual_err", 64'(err), 64'd1);
        wb_ready = 1'b1;
        tick();
        do_reset();
        check("post_reset_err", 64'(err), 64'd0);

        // Forced push at full with no pop: dropped, err sticky.
        for (int i = 0; i < 4; i++) begin
            issue('{cmp: 1'b0, y: 64'hA0 + 64'(i), rob: 4'(i), dst: 4'(i), fcr: 4'd0}, 1'b1);
        end
        tick(); tick();
        check("full_occ", 64'(occupancy), 64'd4);
        f_op = '{cmp: 1'b0, y: 64'hDEAD, rob: 4'd15, dst: 4'd15, fcr: 4'd0};
        f_val = 1'b1;
        tick();
        f_val = 1'b0;
        check("drop_occ", 64'(occupancy), 64'd4);
        check("drop_err", 64'(err), 64'd1);
        wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("drop_drained", 64'(occupancy), 64'd0);
        check("drop_err_sticky", 64'(err), 64'd1);

        // Mid-stream asynchronous reset pulse.
        do_reset();
        wb_ready = 1'b0;
        issue('{cmp: 1'b0, y: 64'hB0, rob: 4'd1, dst: 4'd2, fcr: 4'd0}, 1'b0);
        issue('{cmp: 1'b0, y: 64'hB1, rob: 4'd3, dst: 4'd4, fcr: 4'd0}, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(wb_valid), 64'd0);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_issue_ok", 64'(issue_ok), 64'd0);
        check("mid_rst_data", wb_data, 64'd0);
        check("mid_rst_rob", 64'(wb_rob_ptr), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("after_rst_issue_ok", 64'(issue_ok), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("after_rst_occ", 64'(occupancy), 64'd0);
        check("after_rst_err", 64'(err), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("pop_count", 64'(pops), 64'd31);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_wb_queue.md
# fpu_wb_queue

Completion-side companion to the floating-point execution unit. It captures the unit's fixed-latency result beats, which have no backpressure: arithmetic results destined for the physical register file and compare results destined for the FCR file. It buffers them in a small FIFO and presents them to the writeback/ROB-completion port through a valid/ready handshake. It also tracks operations in flight inside the FPU and issues credits (`issue_ok`), so the scheduler can never start an operation whose result could not be stored.

## Interface
- `LG_PRF_WIDTH`, 4, physical register pointer width
- `LG_ROB_WIDTH`, 4, ROB pointer width
- `LG_FCR_WIDTH`, 4, FCR pointer width
- `FPU_LAT`, 2, FPU start-to-result latency in cycles (≥1)
- `LG_DEPTH`, 2, log2 of FIFO depth; DEPTH = 2^LG_DEPTH, DEPTH > FPU_LAT required
- `clk`  in  1  clock; single clock domain, all state on posedge
- `reset`  in  1  asynchronous, active-low reset
- `issue_start`  in  1  scheduler is asserting FPU `start` this cycle
- `issue_ok`  out  1  scheduler may assert `issue_start` this cycle
- `fpu_val`  in  1  arithmetic result beat
- `fpu_cmp_val`  in  1  compare result beat (merged FCR value)
- `fpu_y`  in  64  result data
- `fpu_rob_ptr` / `fpu_dst_ptr` / `fpu_fcr_ptr`  in  LG_ROB_WIDTH / LG_PRF_WIDTH / LG_FCR_WIDTH  result tags
- `wb_valid`  out  1  head entry valid
- `wb_ready`  in  1  writeback accepts head this cycle
- `wb_is_fcr`  out  1  1 = write `wb_data[7:0]` to FCR `wb_fcr_ptr`; 0 = write `wb_data` to PRF `wb_dst_ptr`
- `wb_data`  out  64  head data
- `wb_rob_ptr` / `wb_dst_ptr` / `wb_fcr_ptr`  out  as above  head tags
- `occupancy`  out  LG_DEPTH+1  FIFO entry count
- `err`  out  1  sticky protocol-violation flag

## Operation
- State:
  - FIFO with DEPTH entries, where each entry is {is_fcr, data, rob, dst, fcr}.
  - Read and write pointers of LG_DEPTH bits that wrap modulo DEPTH.
  - `count` of LG_DEPTH+1 bits.
  - `inflight` of LG_DEPTH+1 bits.
  - `err` register.
- Push when `fpu_val | fpu_cmp_val`. The entry is written with is_fcr = `fpu_cmp_val`.
- Pop when `wb_valid & wb_ready`.
- `wb_valid` = (count != 0). The `wb_*` outputs come from the head entry and are held stable while `wb_valid & !wb_ready`.
- `issue_ok` = (count + inflight < DEPTH), computed from registered state only. A same-cycle pop earns no credit, which keeps the credit conservative.
- `inflight` update each cycle: +1 on `issue_start`, −1 on push. Both in the same cycle leaves it unchanged.
- Full and push together:
  - With a same-cycle pop, both the push and the pop are accepted and `count` is unchanged.
  - With no pop, the push is dropped and `err` is set.
- Empty: the pop is ignored, because `wb_valid` is 0.
- `fpu_val & fpu_cmp_val` in the same cycle: one entry is pushed with is_fcr = 1 and `err` is set.
- Push with `inflight` = 0: the push proceeds, `inflight` stays 0 (saturating), and `err` is set.
- `issue_start` while `issue_ok` = 0: `inflight` still increments and `err` is set.
- `err` clears only on reset.
- Reset assertion, asynchronous and at any time including mid-operation:
  - FIFO emptied, pointers, `count` and `inflight` cleared to 0, `err` cleared to 0.
  - Outputs: `wb_valid` = 0, `occupancy` = 0, `err` = 0, all `wb_*` data and tags = 0.
  - `issue_ok` is forced to 0 while `reset` is low.
  - Operations in flight before reset are discarded; the FPU valid pipeline is reset at the same time.

## Timing
- `issue_start` at cycle t produces an FPU beat at t+FPU_LAT.
  - The entry is written at the end of t+FPU_LAT.
  - `wb_valid` rises in t+FPU_LAT+1, giving 1 cycle of queue latency.
  - There is no bypass from `fpu_*` to `wb_*`.
- The `inflight` decrement and the `count` increment occur at the same edge, so count+inflight is constant across a handoff.
- Throughput: one push and one pop per cycle sustained with `wb_ready` held high.
- Credit limit: with `wb_ready` = 0, at most DEPTH starts are admitted and none are ever dropped.
- First `issue_ok` = 1 is in the first cycle after `reset` deasserts.

## Test plan
- Reset then idle (depth 4, FPU_LAT 2) -> `issue_ok` = 1, `wb_valid` = 0, `occupancy` = 0, `err` = 0; assert reset while `reset` is low -> `issue_ok` = 0.
- Single DP add: start at t=0, beat at t=2 with y=0x4008000000000000, rob=5, dst=9 -> `wb_valid` at t=3 with same data/tags, `wb_is_fcr` = 0; `wb_ready` = 1 -> `occupancy` returns to 0 at t=4.
- Compare beat: `fpu_cmp_val` with y=0x05, fcr=3 -> `wb_is_fcr` = 1, `wb_data` = 0x05, `wb_fcr_ptr` = 3.
- Credit stall: `wb_ready` = 0, start every cycle -> exactly 4 starts accepted, `issue_ok` = 0 thereafter, `occupancy` = 4, `err` = 0; raise `wb_ready` -> 4 pops in order, then `issue_ok` returns to 1 after the first pop.
- Streaming: back-to-back starts with `wb_ready` = 1 for 20 cycles -> 20 results in order, `occupancy` ≤ 1 at steady state, no stall.
- Violations:
  - Force a push at full with no pop -> entry dropped, `occupancy` stays 4, `err` = 1 until reset.
  - Simultaneous `fpu_val` and `fpu_cmp_val` -> one entry pushed with `wb_is_fcr` = 1, `err` = 1.
  - Mid-stream reset pulse -> all state 0 immediately.
